// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared definitions for the iterative unsigned divider.
//               Holds the opcode constants, the default operand width and
//               the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    // Default operand width in bits
    localparam int DEFAULT_WIDTH = 32;

    // Operation select codes seen on the Signal input
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] OUT   = 6'b111111;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration.
//               The partial remainder is shifted left with the next dividend
//               bit entering at bit 0; if the result is not smaller than the
//               divisor, the divisor is subtracted and a 1 quotient bit is
//               produced, otherwise the shifted value passes unchanged.
// Ports       : rem_in       - partial remainder, WIDTH+1 bits
//               dividend_bit - next dividend bit (MSB first)
//               divisor      - divisor, WIDTH bits
//               rem_out      - updated partial remainder, WIDTH+1 bits
//               quot_bit     - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0] w_shifted;
    logic           w_fits;

    assign w_shifted = {rem_in[WIDTH-1:0], dividend_bit};

    // A set top bit on the incoming remainder means the shifted value exceeds
    // any WIDTH-bit divisor, so the subtraction is taken regardless of the
    // truncated comparison. In normal restoring operation that bit is zero.
    assign w_fits   = rem_in[WIDTH] | (w_shifted >= {1'b0, divisor});
    assign rem_out  = w_fits ? (w_shifted - {1'b0, divisor}) : w_shifted;
    assign quot_bit = w_fits;

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock. A request (start with Signal = DIVU) is accepted only
//               in IDLE; the operation then runs for WIDTH cycles and the
//               result {remainder, quotient} is published on dataOut with a
//               one-cycle done pulse. A zero divisor skips the iterations and
//               completes in the cycle right after the accept edge with
//               quotient = all ones, remainder = dividend.
// Ports       : clk       - clock, rising edge
//               reset     - synchronous, active-high
//               start     - division request, sampled only in IDLE
//               Signal    - operation select (DIVU starts, others ignored)
//               dataA     - dividend (unsigned)
//               dataB     - divisor (unsigned)
//               dataOut   - {remainder, quotient}, held until next result
//               busy      - high while iterating
//               done      - one-cycle pulse when dataOut becomes valid
//               divByZero - last accepted operation had a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic [2*WIDTH-1:0]   dataOut,
    output logic                 busy,
    output logic                 done,
    output logic                 divByZero
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;

    // r_dq starts as the dividend and shifts left each step; the vacated
    // LSBs collect quotient bits, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0]     r_dq;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH:0]       r_rem;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_data_out;
    logic                 r_div_by_zero;

    logic                 w_accept;
    logic                 w_zero;
    logic                 w_last;
    logic [WIDTH:0]       w_rem_next;
    logic                 w_quot_bit;
    logic [WIDTH-1:0]     w_dq_next;

    assign w_accept  = (r_state == IDLE) && start && (Signal == DIVU);
    assign w_zero    = (dataB == '0);
    assign w_last    = (r_count == c_LAST);
    assign w_dq_next = {r_dq[WIDTH-2:0], w_quot_bit};

    div_step #(
        .WIDTH        (WIDTH)
    ) u_div_step (
        .rem_in       (r_rem),
        .dividend_bit (r_dq[WIDTH-1]),
        .divisor      (r_divisor),
        .rem_out      (w_rem_next),
        .quot_bit     (w_quot_bit)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dq          <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_count       <= '0;
            r_data_out    <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dq          <= dataA;
                        r_divisor     <= dataB;
                        r_rem         <= '0;
                        r_count       <= '0;
                        r_div_by_zero <= w_zero;
                        if (w_zero) begin
                            r_data_out <= {dataA, {WIDTH{1'b1}}};
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_rem_next;
                    r_dq    <= w_dq_next;
                    r_count <= r_count + 1'b1;
                    // Publish only the finished result; the restored
                    // remainder always fits in WIDTH bits.
                    if (w_last) begin
                        r_data_out <= {w_rem_next[WIDTH-1:0], w_dq_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dataOut   = r_data_out;
    assign divByZero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Self-checking bench for divider (WIDTH = 32). Expected
//               results are computed from the operands and queued when a
//               request is driven, then popped and compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    localparam int W = 32;
    localparam logic [5:0] DIVU_C = 6'b011011;
    localparam logic [5:0] OUT_C  = 6'b111111;

    logic           clk;
    logic           reset;
    logic           start;
    logic [5:0]     Signal;
    logic [W-1:0]   dataA;
    logic [W-1:0]   dataB;
    logic [2*W-1:0] dataOut;
    logic           busy;
    logic           done;
    logic           divByZero;

    typedef struct {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    divider #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Signal    (Signal),
        .dataA     (dataA),
        .dataB     (dataB),
        .dataOut   (dataOut),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one request, wait (bounded) for done and score the result.
    // With interfere set, a second DIVU request is pulsed mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit interfere);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        bit   seen;
        e.quot = (b == 0) ? '1 : a / b;
        e.rem  = (b == 0) ? a : a % b;
        e.dbz  = (b == 0);
        e.lat  = (b == 0) ? 0 : W;
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1; Signal = DIVU_C; dataA = a; dataB = b;
        @(negedge clk);                       // accept edge has just passed
        start = 1'b0; Signal = OUT_C; dataA = $urandom; dataB = $urandom;
        cyc = 0; busy_cnt = 0; seen = 1'b0;
        while (cyc <= 2 * W) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (interfere && cyc == 5) begin
                start = 1'b1; Signal = DIVU_C; dataA = 9; dataB = 2;
            end else begin
                start = 1'b0; Signal = OUT_C;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; Signal = OUT_C;

        check("done_seen", 64'(seen), 64'd1);
        e = sb.pop_front();
        if (seen) begin
            check("latency",     64'(cyc),      64'(e.lat));
            check("busy_cycles", 64'(busy_cnt), 64'(e.lat));
            check("quotient",    64'(dataOut[W-1:0]),   64'(e.quot));
            check("remainder",   64'(dataOut[2*W-1:W]), 64'(e.rem));
            check("divByZero",   64'(divByZero),        64'(e.dbz));
        end
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        bit seen;
        n_vec = 0; n_err = 0;
        reset = 1'b1; start = 1'b0; Signal = OUT_C; dataA = '0; dataB = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_dataOut",   dataOut,          64'd0);
        check("rst_busy",      64'(busy),        64'd0);
        check("rst_done",      64'(done),        64'd0);
        check("rst_divByZero", 64'(divByZero),   64'd0);

        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'd3, 32'd10, 1'b0);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(32'd8, 32'd2, 1'b0);
        run_op(32'd123456789, 32'd1000, 1'b0);

        // Abort a run with reset; also present a start in the reset cycle.
        @(negedge clk);
        start = 1'b1; Signal = DIVU_C; dataA = 32'd1000; dataB = 32'd3;
        @(negedge clk);
        start = 1'b0; Signal = OUT_C;
        repeat (10) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1; start = 1'b1; Signal = DIVU_C;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; Signal = OUT_C;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_dataOut",   dataOut,        64'd0);
        check("abort_divByZero", 64'(divByZero), 64'd0);
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);

        run_op(32'd1000, 32'd3, 1'b0);
        run_op(32'd50, 32'd5, 1'b1);

        // Signal = OUT (even with start high) must leave the result alone.
        repeat (5) begin
            @(negedge clk);
            start = 1'b1; Signal = OUT_C; dataA = $urandom; dataB = $urandom;
            @(negedge clk);
            check("hold_dataOut", dataOut,     {32'd0, 32'd10});
            check("hold_busy",    64'(busy),   64'd0);
            check("hold_done",    64'(done),   64'd0);
        end
        start = 1'b0;

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_leftover: got %0d, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
